// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery operand select buffer.
// Select codes and controller state encoding.
package mont_pkg;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_M    = 2'b10;
  localparam logic [1:0] SEL_BM   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRECOMP = 2'd1,
    ST_READY   = 2'd2
  } state_t;

endpackage

// File: rtl/mont_sync_fifo.sv
// Single-clock FIFO with occupancy flags.
// Head reads as zero while empty so stale entries never leak out.
module mont_sync_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mont_operand_select_buf.sv
// Operand selector for radix-2 Montgomery: returns 0, B, M or B+M
// per select code through a small output FIFO.
module mont_operand_select_buf
  import mont_pkg::*;
#(
  parameter  int K_BITS = 256,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(K_BITS+1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [K_BITS-1:0] i_B,
  input  logic [K_BITS-1:0] i_M,
  input  logic              i_Load_Valid,
  output logic              o_Load_Ready,
  input  logic [1:0]        i_Sel,
  input  logic              i_Sel_Valid,
  output logic              o_Sel_Ready,
  output logic [K_BITS:0]   o_Y,
  output logic              o_Y_Valid,
  input  logic              i_Y_Ready,
  output logic [CNT_W-1:0]  o_Iter,
  output logic              o_Iter_Done
);

  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(K_BITS);

  state_t            state;
  state_t            state_nxt;
  logic [K_BITS-1:0] b_q;
  logic [K_BITS-1:0] m_q;
  logic [K_BITS:0]   sum_q;
  logic [CNT_W-1:0]  iter;
  logic [K_BITS:0]   sel_val;
  logic              load_fire;
  logic              sel_fire;
  logic              fifo_empty;
  logic              fifo_full;

  always_comb begin
    state_nxt    = state;
    o_Load_Ready = 1'b0;
    o_Sel_Ready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_Load_Ready = 1'b1;
        if (i_Load_Valid) state_nxt = ST_PRECOMP;
      end
      ST_PRECOMP: state_nxt = ST_READY;
      ST_READY: begin
        o_Load_Ready = fifo_empty;
        o_Sel_Ready  = !fifo_full;
        if (i_Load_Valid && fifo_empty) state_nxt = ST_PRECOMP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign load_fire = i_Load_Valid && o_Load_Ready;
  assign sel_fire  = i_Sel_Valid && o_Sel_Ready;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= ST_IDLE;
      b_q   <= '0;
      m_q   <= '0;
      sum_q <= '0;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      if (load_fire) begin
        b_q  <= i_B;
        m_q  <= i_M;
        iter <= '0;
      end else if (sel_fire && iter != ITER_MAX) begin
        iter <= iter + 1'b1;
      end
      if (state == ST_PRECOMP) begin
        sum_q <= {1'b0, b_q} + {1'b0, m_q};
      end
    end
  end

  // Selection uses the registered operands, so a select racing a load
  // still sees the old B and M.
  always_comb begin
    sel_val = '0;
    unique case (1'b1)
      (i_Sel == SEL_ZERO): sel_val = '0;
      (i_Sel == SEL_B):    sel_val = {1'b0, b_q};
      (i_Sel == SEL_M):    sel_val = {1'b0, m_q};
      (i_Sel == SEL_BM):   sel_val = sum_q;
      default:             sel_val = '0;
    endcase
  end

  mont_sync_fifo #(
    .WIDTH (K_BITS+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .push  (sel_fire),
    .wdata (sel_val),
    .pop   (i_Y_Ready),
    .rdata (o_Y),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_Y_Valid   = !fifo_empty;
  assign o_Iter      = iter;
  assign o_Iter_Done = (iter == ITER_MAX);

endmodule
